// File: rtl/l1_gan_pkg.sv
// Shared constants for the l1_gan parameter loader: word width, slot map and FSM states.
// Each bus occupies a contiguous run of stream slots with its first word at the LSB.
package l1_gan_pkg;

    localparam int DW      = 16;
    localparam int N_PARAM = 73;
    localparam int N_X     = 4;
    localparam int CW      = 7;

    localparam int L1_W_OFS = 0;   localparam int L1_W_N = 16;
    localparam int L1_B_OFS = 16;  localparam int L1_B_N = 4;
    localparam int L2_W_OFS = 20;  localparam int L2_W_N = 8;
    localparam int L2_B_OFS = 28;  localparam int L2_B_N = 2;
    localparam int L3_W_OFS = 30;  localparam int L3_W_N = 2;
    localparam int L3_B_OFS = 32;  localparam int L3_B_N = 1;
    localparam int L4_W_OFS = 33;  localparam int L4_W_N = 1;
    localparam int L4_B_OFS = 34;  localparam int L4_B_N = 1;
    localparam int L5_W_OFS = 35;  localparam int L5_W_N = 1;
    localparam int L5_B_OFS = 36;  localparam int L5_B_N = 1;
    localparam int L6_W_OFS = 37;  localparam int L6_W_N = 2;
    localparam int L6_B_OFS = 39;  localparam int L6_B_N = 2;
    localparam int L7_W_OFS = 41;  localparam int L7_W_N = 8;
    localparam int L7_B_OFS = 49;  localparam int L7_B_N = 4;
    localparam int L8_W_OFS = 53;  localparam int L8_W_N = 16;
    localparam int L8_B_OFS = 69;  localparam int L8_B_N = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_LOAD_P = 2'b01,
        ST_LOAD_X = 2'b10
    } state_e;

endpackage

// File: rtl/l1_gan_loader_word_demux.sv
// Decodes the word counter into one-hot write enables for the parameter and input slots.
module l1_gan_word_demux
    import l1_gan_pkg::*;
(
    input  logic              i_we_p,
    input  logic              i_we_x,
    input  logic [CW-1:0]     i_cnt,
    output logic [N_PARAM-1:0] o_we_p,
    output logic [N_X-1:0]    o_we_x
);

    // Slot select: exactly one enable per accepted word, none when idle
    always_comb begin
        o_we_p = '0;
        o_we_x = '0;
        for (int i = 0; i < N_PARAM; i++) begin
            o_we_p[i] = i_we_p && (i_cnt == CW'(i));
        end
        for (int j = 0; j < N_X; j++) begin
            o_we_x[j] = i_we_x && (i_cnt == CW'(j));
        end
    end

endmodule

// File: rtl/l1_gan_loader.sv
// Serial loader for l1_gan: assembles 73 parameter words and 4 input words into
// registered buses, with an input-only reload path that reuses stored parameters.
module l1_gan_loader
    import l1_gan_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load_all,
    input  logic          load_x,
    input  logic [DW-1:0] in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [DW-1:0] x1,
    output logic [DW-1:0] x2,
    output logic [DW-1:0] x3,
    output logic [DW-1:0] x4,
    output logic [255:0]  L1_w,
    output logic [63:0]   L1_b,
    output logic [127:0]  L2_w,
    output logic [31:0]   L2_b,
    output logic [31:0]   L3_w,
    output logic [15:0]   L3_b,
    output logic [15:0]   L4_w,
    output logic [15:0]   L4_b,
    output logic [15:0]   L5_w,
    output logic [15:0]   L5_b,
    output logic [31:0]   L6_w,
    output logic [31:0]   L6_b,
    output logic [127:0]  L7_w,
    output logic [63:0]   L7_b,
    output logic [255:0]  L8_w,
    output logic [63:0]   L8_b,
    output logic          out_valid,
    output logic          frame_done,
    output logic          cmd_err
);

    state_e                r_state;
    state_e                w_state_nxt;
    logic [CW-1:0]         r_cnt;
    logic [CW-1:0]         w_cnt_nxt;
    logic                  r_params_loaded;
    logic                  w_params_loaded_nxt;
    logic                  r_out_valid;
    logic                  w_out_valid_nxt;
    logic                  r_frame_done;
    logic                  w_frame_done_nxt;
    logic                  r_cmd_err;
    logic                  w_cmd_err_nxt;
    logic                  r_in_ready;
    logic                  w_xfer;
    logic                  w_we_p;
    logic                  w_we_x;
    logic [N_PARAM-1:0]    w_we_p_vec;
    logic [N_X-1:0]        w_we_x_vec;
    logic [N_PARAM*DW-1:0] r_params;
    logic [DW-1:0]         r_x [N_X];

    assign w_xfer = in_valid && r_in_ready;

    // Next-state, counter and status-flag decode
    always_comb begin
        w_state_nxt         = r_state;
        w_cnt_nxt           = r_cnt;
        w_params_loaded_nxt = r_params_loaded;
        w_out_valid_nxt     = r_out_valid;
        w_frame_done_nxt    = 1'b0;
        w_cmd_err_nxt       = 1'b0;
        w_we_p              = 1'b0;
        w_we_x              = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (load_all) begin
                    w_state_nxt         = ST_LOAD_P;
                    w_cnt_nxt           = '0;
                    w_params_loaded_nxt = 1'b0;
                    w_out_valid_nxt     = 1'b0;
                end else if (load_x) begin
                    if (r_params_loaded) begin
                        w_state_nxt     = ST_LOAD_X;
                        w_cnt_nxt       = '0;
                        w_out_valid_nxt = 1'b0;
                    end else begin
                        w_cmd_err_nxt   = 1'b1;
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_LOAD_P: begin
                if (w_xfer) begin
                    w_we_p = 1'b1;
                    if (r_cnt == CW'(N_PARAM - 1)) begin
                        w_state_nxt         = ST_LOAD_X;
                        w_cnt_nxt           = '0;
                        w_params_loaded_nxt = 1'b1;
                    end else begin
                        w_cnt_nxt = r_cnt + CW'(1);
                    end
                end else begin
                    w_cnt_nxt = r_cnt;
                end
            end
            ST_LOAD_X: begin
                if (w_xfer) begin
                    w_we_x = 1'b1;
                    if (r_cnt == CW'(N_X - 1)) begin
                        w_state_nxt      = ST_IDLE;
                        w_cnt_nxt        = '0;
                        w_frame_done_nxt = 1'b1;
                        w_out_valid_nxt  = 1'b1;
                    end else begin
                        w_cnt_nxt = r_cnt + CW'(1);
                    end
                end else begin
                    w_cnt_nxt = r_cnt;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // FSM state, counter and registered status outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state         <= ST_IDLE;
            r_cnt           <= '0;
            r_params_loaded <= 1'b0;
            r_out_valid     <= 1'b0;
            r_frame_done    <= 1'b0;
            r_cmd_err       <= 1'b0;
            r_in_ready      <= 1'b0;
        end else begin
            r_state         <= w_state_nxt;
            r_cnt           <= w_cnt_nxt;
            r_params_loaded <= w_params_loaded_nxt;
            r_out_valid     <= w_out_valid_nxt;
            r_frame_done    <= w_frame_done_nxt;
            r_cmd_err       <= w_cmd_err_nxt;
            r_in_ready      <= (w_state_nxt != ST_IDLE);
        end
    end

    l1_gan_word_demux u_demux (
        .i_we_p (w_we_p),
        .i_we_x (w_we_x),
        .i_cnt  (r_cnt),
        .o_we_p (w_we_p_vec),
        .o_we_x (w_we_x_vec)
    );

    // Parameter and input word storage, raw bit patterns
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_params <= '0;
            for (int j = 0; j < N_X; j++) begin
                r_x[j] <= '0;
            end
        end else begin
            for (int i = 0; i < N_PARAM; i++) begin
                if (w_we_p_vec[i]) begin
                    r_params[i*DW +: DW] <= in_data;
                end
            end
            for (int j = 0; j < N_X; j++) begin
                if (w_we_x_vec[j]) begin
                    r_x[j] <= in_data;
                end
            end
        end
    end

    assign in_ready   = r_in_ready;
    assign out_valid  = r_out_valid;
    assign frame_done = r_frame_done;
    assign cmd_err    = r_cmd_err;

    assign x1 = r_x[0];
    assign x2 = r_x[1];
    assign x3 = r_x[2];
    assign x4 = r_x[3];

    assign L1_w = r_params[L1_W_OFS*DW +: L1_W_N*DW];
    assign L1_b = r_params[L1_B_OFS*DW +: L1_B_N*DW];
    assign L2_w = r_params[L2_W_OFS*DW +: L2_W_N*DW];
    assign L2_b = r_params[L2_B_OFS*DW +: L2_B_N*DW];
    assign L3_w = r_params[L3_W_OFS*DW +: L3_W_N*DW];
    assign L3_b = r_params[L3_B_OFS*DW +: L3_B_N*DW];
    assign L4_w = r_params[L4_W_OFS*DW +: L4_W_N*DW];
    assign L4_b = r_params[L4_B_OFS*DW +: L4_B_N*DW];
    assign L5_w = r_params[L5_W_OFS*DW +: L5_W_N*DW];
    assign L5_b = r_params[L5_B_OFS*DW +: L5_B_N*DW];
    assign L6_w = r_params[L6_W_OFS*DW +: L6_W_N*DW];
    assign L6_b = r_params[L6_B_OFS*DW +: L6_B_N*DW];
    assign L7_w = r_params[L7_W_OFS*DW +: L7_W_N*DW];
    assign L7_b = r_params[L7_B_OFS*DW +: L7_B_N*DW];
    assign L8_w = r_params[L8_W_OFS*DW +: L8_W_N*DW];
    assign L8_b = r_params[L8_B_OFS*DW +: L8_B_N*DW];

endmodule

// File: tb/tb_l1_gan_loader.sv
// Self-checking bench for l1_gan_loader: command table, directed corner sequences
// and randomized loads compared against a word-array model of the stream layout.
module tb_l1_gan_loader;

    logic          clk = 1'b0;
    logic          rst_n, load_all, load_x, in_valid;
    logic [15:0]   in_data;
    logic          in_ready, out_valid, frame_done, cmd_err;
    logic [15:0]   x1, x2, x3, x4;
    logic [255:0]  L1_w, L8_w;
    logic [127:0]  L2_w, L7_w;
    logic [63:0]   L1_b, L7_b, L8_b;
    logic [31:0]   L2_b, L3_w, L6_w, L6_b;
    logic [15:0]   L3_b, L4_w, L4_b, L5_w, L5_b;

    always #5 clk = ~clk;

    l1_gan_loader dut (
        .clk(clk), .rst_n(rst_n), .load_all(load_all), .load_x(load_x),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .x1(x1), .x2(x2), .x3(x3), .x4(x4),
        .L1_w(L1_w), .L1_b(L1_b), .L2_w(L2_w), .L2_b(L2_b),
        .L3_w(L3_w), .L3_b(L3_b), .L4_w(L4_w), .L4_b(L4_b),
        .L5_w(L5_w), .L5_b(L5_b), .L6_w(L6_w), .L6_b(L6_b),
        .L7_w(L7_w), .L7_b(L7_b), .L8_w(L8_w), .L8_b(L8_b),
        .out_valid(out_valid), .frame_done(frame_done), .cmd_err(cmd_err)
    );

    int n_chk  = 0;
    int n_pass = 0;
    int fd_cnt = 0;

    logic [15:0] mp [73];
    logic [15:0] mx [4];

    typedef struct {
        bit la;
        bit lx;
        bit e_cmd_err;
        bit e_in_ready;
        bit e_out_valid;
    } vec_t;
    vec_t tbl [5];

    always @(negedge clk) if (frame_done === 1'b1) fd_cnt++;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    function automatic logic [255:0] pk(input int ofs, input int cnt);
        logic [255:0] r = '0;
        for (int k = 0; k < cnt; k++) r[16*k +: 16] = mp[ofs+k];
        return r;
    endfunction

    task automatic check_all();
        chk("L1_w", L1_w, pk(0, 16));   chk("L1_b", L1_b, pk(16, 4));
        chk("L2_w", L2_w, pk(20, 8));   chk("L2_b", L2_b, pk(28, 2));
        chk("L3_w", L3_w, pk(30, 2));   chk("L3_b", L3_b, pk(32, 1));
        chk("L4_w", L4_w, pk(33, 1));   chk("L4_b", L4_b, pk(34, 1));
        chk("L5_w", L5_w, pk(35, 1));   chk("L5_b", L5_b, pk(36, 1));
        chk("L6_w", L6_w, pk(37, 2));   chk("L6_b", L6_b, pk(39, 2));
        chk("L7_w", L7_w, pk(41, 8));   chk("L7_b", L7_b, pk(49, 4));
        chk("L8_w", L8_w, pk(53, 16));  chk("L8_b", L8_b, pk(69, 4));
        chk("x1", x1, mx[0]); chk("x2", x2, mx[1]);
        chk("x3", x3, mx[2]); chk("x4", x4, mx[3]);
    endtask

    task automatic cmd(input bit la, input bit lx);
        load_all = la;
        load_x   = lx;
        tick();
        load_all = 1'b0;
        load_x   = 1'b0;
    endtask

    task automatic xfer(input logic [15:0] w, input int gap, output bit ok);
        in_valid = 1'b0;
        repeat (gap) tick();
        in_data  = w;
        in_valid = 1'b1;
        ok = 1'b0;
        for (int t = 0; t < 20; t++) begin
            if (in_ready === 1'b1) begin
                tick();
                ok = 1'b1;
                break;
            end
            tick();
        end
        in_valid = 1'b0;
    endtask

    // Streams one frame from the model; inject_at >= 1 fires both commands mid-frame
    task automatic send_frame(input bit full, input int gap_mode, input int inject_at);
        int n;
        int fd0;
        int gap;
        bit early;
        bit ok;
        logic [15:0] w;
        n = full ? 77 : 4;
        fd0 = fd_cnt;
        early = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (i == inject_at && i > 0) begin
                cmd(1'b1, 1'b1);
                chk("mid_load_cmd_no_err", cmd_err, 1'b0);
            end
            if (full) w = (i < 73) ? mp[i] : mx[i-73];
            else      w = mx[i];
            gap = (gap_mode == 0) ? 0 : (gap_mode == 1) ? 1 : int'($urandom_range(0, 2));
            xfer(w, gap, ok);
            if (!ok) begin
                chk("xfer_timeout", 1'b0, 1'b1);
                return;
            end
            if (i == 0) chk("first_word_latency", full ? L1_w[15:0] : x1, w);
            if (i < n - 1 && (frame_done !== 1'b0 || out_valid !== 1'b0)) early = 1'b1;
        end
        chk("no_early_done_or_valid", early, 1'b0);
        chk("frame_done_rise", frame_done, 1'b1);
        chk("out_valid_rise", out_valid, 1'b1);
        chk("in_ready_back_idle", in_ready, 1'b0);
        tick();
        chk("frame_done_one_cycle", frame_done, 1'b0);
        chk("frame_done_count", fd_cnt - fd0, 1);
    endtask

    task automatic zero_model();
        for (int i = 0; i < 73; i++) mp[i] = 16'h0000;
        for (int j = 0; j < 4; j++)  mx[j] = 16'h0000;
    endtask

    task automatic rand_model(input bit params);
        if (params) for (int i = 0; i < 73; i++) mp[i] = 16'($urandom);
        for (int j = 0; j < 4; j++) mx[j] = 16'($urandom);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [15:0] sp [73];
        logic [15:0] sx [4];
        bit ok;
        int fd0;

        rst_n = 1'b0; load_all = 1'b0; load_x = 1'b0; in_valid = 1'b0; in_data = 16'h0000;
        tick(); tick();
        zero_model();
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_frame_done", frame_done, 1'b0);
        chk("rst_cmd_err", cmd_err, 1'b0);
        chk("rst_in_ready", in_ready, 1'b0);
        check_all();
        rst_n = 1'b1;

        // bench parameter set
        for (int i = 0; i < 73; i++) mp[i] = 16'(i * 3 - 50);
        mp[0]  = 16'd6;
        mp[16] = 16'd1;  mp[17] = 16'd0;  mp[18] = 16'd2;  mp[19] = 16'hFFFF;
        mp[32] = 16'd5;
        mp[36] = 16'hFFFC;
        mp[69] = 16'hFFF6; mp[70] = 16'd10; mp[71] = 16'd10; mp[72] = 16'hFFF6;
        mx[0] = 16'd0; mx[1] = 16'd1; mx[2] = 16'd1; mx[3] = 16'd0;

        tbl[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[2] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[4] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        for (int v = 0; v < 5; v++) begin
            cmd(tbl[v].la, tbl[v].lx);
            chk("tbl_cmd_err", cmd_err, tbl[v].e_cmd_err);
            chk("tbl_in_ready", in_ready, tbl[v].e_in_ready);
            chk("tbl_out_valid", out_valid, tbl[v].e_out_valid);
        end

        send_frame(1'b1, 0, 5);
        chk("L1_b_bench", L1_b, {16'hFFFF, 16'h0002, 16'h0000, 16'h0001});
        chk("L3_b_bench", L3_b, 16'h0005);
        chk("L5_b_bench", L5_b, 16'hFFFC);
        chk("L8_b_bench", L8_b, {16'hFFF6, 16'h000A, 16'h000A, 16'hFFF6});
        chk("x2_bench", x2, 16'h0001);
        check_all();

        mx[0] = 16'd3; mx[1] = 16'hFFFE; mx[2] = 16'd7; mx[3] = 16'd0;
        cmd(1'b0, 1'b1);
        chk("xreload_cmd_err", cmd_err, 1'b0);
        chk("xreload_in_ready", in_ready, 1'b1);
        chk("xreload_out_valid_low", out_valid, 1'b0);
        send_frame(1'b0, 0, -1);
        check_all();

        cmd(1'b1, 1'b0);
        chk("stall_out_valid_low", out_valid, 1'b0);
        send_frame(1'b1, 1, -1);
        check_all();

        rand_model(1'b1);
        cmd(1'b1, 1'b0);
        fd0 = fd_cnt;
        for (int i = 0; i < 40; i++) xfer(mp[i], 0, ok);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 73; i++) sp[i] = mp[i];
        for (int j = 0; j < 4; j++)  sx[j] = mx[j];
        zero_model();
        check_all();
        chk("abort_in_ready", in_ready, 1'b0);
        chk("abort_out_valid", out_valid, 1'b0);
        repeat (3) tick();
        chk("abort_no_frame_done", fd_cnt - fd0, 0);
        cmd(1'b0, 1'b1);
        chk("abort_params_cleared", cmd_err, 1'b1);
        for (int i = 0; i < 73; i++) mp[i] = sp[i];
        for (int j = 0; j < 4; j++)  mx[j] = sx[j];
        cmd(1'b1, 1'b0);
        send_frame(1'b1, 2, -1);
        check_all();

        for (int r = 0; r < 6; r++) begin
            bit full;
            full = (r == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            rand_model(full);
            cmd(full, !full);
            chk("rand_out_valid_low", out_valid, 1'b0);
            send_frame(full, 2, full ? int'($urandom_range(1, 72)) : -1);
            check_all();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/l1_gan_loader.md
Name: l1_gan_loader

Overview:
- Upstream stage of l1_gan: receives a serial stream of 16-bit signed words and assembles the packed L1_w..L8_b parameter buses and the x1..x4 inputs that l1_gan consumes combinationally.
- Supports a full load (73 parameter words, then 4 input words) or an input-only reload (4 words) that reuses the stored parameters.
- Asserts out_valid when the registered buses form a complete, consistent set for l1_gan.

Parameters:
- DW, 16, word width; must equal l1_gan's 16-bit datapath.
- N_PARAM, 73, localparam: parameter words per full load.
- N_X, 4, localparam: input words per frame.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous reset, active-low.
- load_all  in  1  pulse: start a full load (73 parameter words, then 4 x words).
- load_x  in  1  pulse: start an x-only load (4 words).
- in_data  in  DW  signed stream word.
- in_valid  in  1  in_data valid.
- in_ready  out  1  loader accepts a word; a transfer occurs when in_valid && in_ready.
- x1, x2, x3, x4  out  DW each  registered network inputs.
- L1_w 256, L1_b 64, L2_w 128, L2_b 32, L3_w 32, L3_b 16, L4_w 16, L4_b 16, L5_w 16, L5_b 16, L6_w 32, L6_b 32, L7_w 128, L7_b 64, L8_w 256, L8_b 64: all out, registered, same packing as l1_gan.
- out_valid  out  1  level: buses complete.
- frame_done  out  1  one-cycle pulse after the final word of any load.
- cmd_err  out  1  one-cycle pulse when load_x is rejected.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - All buses and x registers reset to 0.
  - out_valid, frame_done, cmd_err, in_ready = 0; params_loaded flag = 0.
  - FSM goes to IDLE, word counter to 0.
  - Reset mid-load aborts the load; no partial result is reported valid.
- FSM states and transitions:
  - IDLE: in_ready = 0.
    - load_all -> LOAD_P and clear params_loaded.
    - load_x with params_loaded=1 -> LOAD_X.
    - load_x with params_loaded=0 -> stay in IDLE and pulse cmd_err next cycle.
    - load_all and load_x in the same cycle -> load_all wins, no cmd_err.
  - LOAD_P: in_ready = 1.
    - Each accepted word is written to the slot selected by the counter (0..72), then the counter increments.
    - After word 72 -> LOAD_X, counter = 0, params_loaded = 1.
  - LOAD_X: in_ready = 1.
    - Words 0..3 go to x1..x4.
    - After word 3 -> IDLE, frame_done = 1 for the next cycle, out_valid = 1.
- out_valid deasserts in the cycle after either load command is accepted and stays low until that load's frame_done.
  - Buses may change word by word during a load; consumers must gate on out_valid.
- Load commands during LOAD_P or LOAD_X are ignored (no restart, no cmd_err).
- in_valid = 0 stalls the load indefinitely; the counter holds.
- Word order and slot mapping (cumulative index):
  - L1_w 0-15, L1_b 16-19, L2_w 20-27, L2_b 28-29, L3_w 30-31, L3_b 32.
  - L4_w 33, L4_b 34, L5_w 35, L5_b 36, L6_w 37-38, L6_b 39-40.
  - L7_w 41-48, L7_b 49-52, L8_w 53-68, L8_b 69-72.
  - The k-th word within a bus lands at bits [DW*k+DW-1 : DW*k]; the first word sent is w11/b1 (LSB slot).
- Latency: the word is visible on its bus output one cycle after the transfer. out_valid and frame_done rise one cycle after the final transfer.
- Stored as raw bit patterns; no arithmetic, saturation or sign handling.

Decomposition:
- Shared package l1_gan_pkg:
  - DW.
  - Per-layer word counts and start offsets (L1_W_OFS=0 ... L8_B_OFS=69).
  - N_PARAM, N_X, and FSM state encodings.
- Optional sub-module l1_gan_word_demux: counter index + word in -> slot write-enable decode. Otherwise a single module.

Test Plan:
- Reset then load_all; stream the l1_gan bench set (L1_w first word 6, ..., L8_b last word -10), then x = 0,1,1,0 -> L1_b = {-1,2,0,1}, L3_b = 5, L5_b = -4, L8_b = {-10,10,10,-10}, x2 = 1. frame_done pulses once; out_valid = 1.
- After a full load: load_x then 3,-2,7,0 -> x1..x4 = 3,-2,7,0, all L buses unchanged, frame_done pulses, out_valid low only during the reload.
- load_x straight after reset -> cmd_err pulses one cycle, in_ready stays 0, out_valid stays 0.
- Full load with in_valid toggled 0/1 every cycle -> same final buses as the back-to-back load; frame_done arrives after exactly 77 transfers.
- rst_n low after 40 accepted words, then a full reload -> all buses 0 immediately after reset; the reload result is correct; no frame_done from the aborted load.
- load_all and load_x in the same IDLE cycle -> full load starts, no cmd_err; a load_all issued during LOAD_P is ignored (counter is not restarted).
